ram_banked_clr: RTL and testbench

- Parametrised successor to the fixed-size hierarchical RAM chips: a generic banked RAM with configurable word width, bank count and rows per bank.
- Adds a hardware clear sequencer. After reset, or on request, it zeroes every word before accepting accesses, and signals this with a ready flag.
- Intended as the data-memory building block for the CPU/memory stage. Default geometry (8 banks x 64 rows x 16 bits) matches the existing 512-word part.

---
 rtl/ram_pkg.sv | 14 +
 rtl/ram_bank.sv | 30 +++
 rtl/ram_banked_clr.sv | 120 ++++++++++++
 tb/tb_ram_banked_clr.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the banked RAM with hardware clear sequencer:
// sequencer state encoding and default geometry.
package ram_pkg;

    typedef enum logic {
        RAM_ST_CLEAR = 1'b0,
        RAM_ST_READY = 1'b1
    } ram_state_e;

    localparam int RAM_WIDTH     = 16;
    localparam int RAM_BANK_BITS = 3;
    localparam int RAM_ROW_BITS  = 6;

endpackage

// File: rtl/ram_bank.sv
// One bank of the banked RAM: single synchronous write port and a
// combinational read port. Contents are not reset; the top sweeps them.
module ram_bank
    import ram_pkg::*;
#(
    parameter int WIDTH    = RAM_WIDTH,
    parameter int ROW_BITS = RAM_ROW_BITS
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [ROW_BITS-1:0] wr_row,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic [ROW_BITS-1:0] rd_row,
    output logic [WIDTH-1:0]    rd_data
);

    localparam int ROWS = 2 ** ROW_BITS;

    logic [WIDTH-1:0] mem_r [ROWS];

    // Storage write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_row] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_row];

endmodule

// File: rtl/ram_banked_clr.sv
// Banked RAM with a clear sequencer that zeroes one row in every bank per
// cycle after reset or on clear_req; ready is low while the sweep runs.
module ram_banked_clr
    import ram_pkg::*;
#(
    parameter int WIDTH     = RAM_WIDTH,
    parameter int BANK_BITS = RAM_BANK_BITS,
    parameter int ROW_BITS  = RAM_ROW_BITS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              in,
    input  logic                          load,
    input  logic [BANK_BITS+ROW_BITS-1:0] address,
    input  logic                          clear_req,
    output logic [WIDTH-1:0]              out,
    output logic                          ready
);

    localparam int ADDR_W = BANK_BITS + ROW_BITS;
    localparam int NBANK  = 2 ** BANK_BITS;

    ram_state_e           state_r;
    ram_state_e           state_nxt_s;
    logic [ROW_BITS-1:0]  clr_row_r;
    logic [ROW_BITS-1:0]  clr_row_nxt_s;
    logic [BANK_BITS-1:0] bank_sel_s;
    logic [ROW_BITS-1:0]  row_sel_s;
    logic [ROW_BITS-1:0]  wr_row_s;
    logic [WIDTH-1:0]     wr_data_s;
    logic [NBANK-1:0]     bank_we_s;
    logic [WIDTH-1:0]     rd_data_s [NBANK];

    assign bank_sel_s = address[ADDR_W-1:ROW_BITS];
    assign row_sel_s  = address[ROW_BITS-1:0];

    // Sequencer state and clear-row counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= RAM_ST_CLEAR;
            clr_row_r <= {ROW_BITS{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            clr_row_r <= clr_row_nxt_s;
        end
    end

    // Next-state logic: sweep all rows, then serve accesses until clear_req
    always_comb begin
        state_nxt_s   = state_r;
        clr_row_nxt_s = clr_row_r;
        case (state_r)
            RAM_ST_CLEAR: begin
                clr_row_nxt_s = clr_row_r + ROW_BITS'(1);
                if (clr_row_r == {ROW_BITS{1'b1}}) begin
                    state_nxt_s = RAM_ST_READY;
                end else begin
                    state_nxt_s = RAM_ST_CLEAR;
                end
            end
            RAM_ST_READY: begin
                if (clear_req) begin
                    state_nxt_s   = RAM_ST_CLEAR;
                    clr_row_nxt_s = {ROW_BITS{1'b0}};
                end else begin
                    state_nxt_s   = RAM_ST_READY;
                    clr_row_nxt_s = clr_row_r;
                end
            end
            default: begin
                state_nxt_s   = RAM_ST_CLEAR;
                clr_row_nxt_s = {ROW_BITS{1'b0}};
            end
        endcase
    end

    // Write-port steering: sweep row with zero data, else the addressed word
    always_comb begin
        wr_row_s  = row_sel_s;
        wr_data_s = in;
        bank_we_s = {NBANK{1'b0}};
        if (reset) begin
            bank_we_s = {NBANK{1'b0}};
        end else if (state_r == RAM_ST_CLEAR) begin
            wr_row_s  = clr_row_r;
            wr_data_s = {WIDTH{1'b0}};
            bank_we_s = {NBANK{1'b1}};
        end else if (load && !clear_req) begin
            bank_we_s[bank_sel_s] = 1'b1;
        end else begin
            bank_we_s = {NBANK{1'b0}};
        end
    end

    for (genvar g = 0; g < NBANK; g++) begin : g_bank
        ram_bank #(
            .WIDTH    (WIDTH),
            .ROW_BITS (ROW_BITS)
        ) u_bank (
            .clk     (clk),
            .wr_en   (bank_we_s[g]),
            .wr_row  (wr_row_s),
            .wr_data (wr_data_s),
            .rd_row  (row_sel_s),
            .rd_data (rd_data_s[g])
        );
    end

    // Output bank mux, held at zero until the sweep has finished
    always_comb begin
        if (state_r == RAM_ST_READY) begin
            out = rd_data_s[bank_sel_s];
        end else begin
            out = {WIDTH{1'b0}};
        end
    end

    assign ready = (state_r == RAM_ST_READY);

endmodule

// File: tb/tb_ram_banked_clr.sv
// Self-checking bench for ram_banked_clr: default geometry plus a small
// 8-bit, 2-bank, 4-row instance driven from the same stimulus.
module tb_ram_banked_clr;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic        clear_req = 1'b0;
    logic [8:0]  address = 9'd0;
    logic [15:0] in = 16'd0;
    logic [15:0] out;
    logic        ready;
    logic [7:0]  out_s;
    logic        ready_s;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    // Reference state: remaining clear cycles and word contents
    int          m_left = 64;
    logic [15:0] m_mem [512];
    int          sm_left = 4;
    logic [7:0]  sm_mem [8];

    always #5 clk = ~clk;

    ram_banked_clr dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .load      (load),
        .address   (address),
        .clear_req (clear_req),
        .out       (out),
        .ready     (ready)
    );

    ram_banked_clr #(.WIDTH(8), .BANK_BITS(1), .ROW_BITS(2)) dut_s (
        .clk       (clk),
        .reset     (reset),
        .in        (in[7:0]),
        .load      (load),
        .address   (address[2:0]),
        .clear_req (clear_req),
        .out       (out_s),
        .ready     (ready_s)
    );

    // A clear zeroes the memory and makes it unusable for 2^ROW_BITS edges
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left <= 64;
            for (int i = 0; i < 512; i++) m_mem[i] <= 16'd0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
        end else if (clear_req) begin
            m_left <= 64;
            for (int i = 0; i < 512; i++) m_mem[i] <= 16'd0;
        end else if (load) begin
            m_mem[address] <= in;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sm_left <= 4;
            for (int i = 0; i < 8; i++) sm_mem[i] <= 8'd0;
        end else if (sm_left != 0) begin
            sm_left <= sm_left - 1;
        end else if (clear_req) begin
            sm_left <= 4;
            for (int i = 0; i < 8; i++) sm_mem[i] <= 8'd0;
        end else if (load) begin
            sm_mem[address[2:0]] <= in[7:0];
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the reference
    always @(negedge clk) begin
        if (cmp_en) begin
            check("ready", 32'(ready), 32'(m_left == 0));
            check("out", 32'(out), (m_left == 0) ? 32'(m_mem[address]) : 32'd0);
            check("ready_small", 32'(ready_s), 32'(sm_left == 0));
            check("out_small", 32'(out_s), (sm_left == 0) ? 32'(sm_mem[address[2:0]]) : 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [8:0] a, input logic [15:0] d);
        step();
        clear_req = 1'b0;
        address = a;
        in = d;
        load = 1'b1;
    endtask

    task automatic rd(input logic [8:0] a, input logic [15:0] exp, input string nm);
        step();
        load = 1'b0;
        clear_req = 1'b0;
        address = a;
        @(negedge clk);
        check(nm, 32'(out), 32'(exp));
    endtask

    task automatic rd_s(input logic [8:0] a, input logic [7:0] exp, input string nm);
        step();
        load = 1'b0;
        clear_req = 1'b0;
        address = a;
        @(negedge clk);
        check(nm, 32'(out_s), 32'(exp));
    endtask

    // Counts low-ready negedges of each instance until both are ready
    task automatic wait_ready(output int n, output int ns);
        n = 0;
        ns = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (ready && ready_s) break;
            if (!ready) n++;
            if (!ready_s) ns++;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ns;
        #1 reset = 1'b1;
        #1 cmp_en = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        repeat (3) step();
        reset = 1'b0;
        wait_ready(n, ns);
        check("clear_cycles", 32'(n), 32'd64);
        check("clear_cycles_small", 32'(ns), 32'd4);
        rd(9'd0, 16'h0000, "clr_rd0");
        rd(9'd63, 16'h0000, "clr_rd63");
        rd(9'd64, 16'h0000, "clr_rd64");
        rd(9'd511, 16'h0000, "clr_rd511");

        wr(9'd0, 16'hA5A5);
        wr(9'd63, 16'h1234);
        wr(9'd64, 16'hBEEF);
        wr(9'd511, 16'h7FFF);
        rd(9'd0, 16'hA5A5, "wr_rd0");
        rd(9'd63, 16'h1234, "wr_rd63");
        rd(9'd64, 16'hBEEF, "wr_rd64");
        rd(9'd511, 16'h7FFF, "wr_rd511");
        rd(9'd128, 16'h0000, "bank_iso128");

        wr(9'd100, 16'h0011);
        step();
        address = 9'd100;
        in = 16'h2222;
        load = 1'b1;
        @(negedge clk);
        check("rdw_before", 32'(out), 32'h0011);
        step();
        load = 1'b0;
        @(negedge clk);
        check("rdw_after", 32'(out), 32'h2222);

        step();
        clear_req = 1'b1;
        load = 1'b1;
        address = 9'd5;
        in = 16'hFFFF;
        step();
        clear_req = 1'b0;
        load = 1'b0;
        wait_ready(n, ns);
        check("req_clear_cycles", 32'(n), 32'd64);
        check("req_clear_cycles_small", 32'(ns), 32'd4);
        rd(9'd5, 16'h0000, "req_rd5");
        rd(9'd511, 16'h0000, "req_rd511");
        rd(9'd0, 16'h0000, "req_rd0");

        step();
        clear_req = 1'b1;
        load = 1'b0;
        step();
        clear_req = 1'b0;
        address = 9'd10;
        in = 16'h5555;
        load = 1'b1;
        n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (ready) break;
            n++;
            #1;
            clear_req = (n == 30);
            load = (n < 40);
        end
        load = 1'b0;
        clear_req = 1'b0;
        check("ign_clear_cycles", 32'(n), 32'd64);
        rd(9'd10, 16'h0000, "ign_rd10");

        step();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (19) step();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        wait_ready(n, ns);
        check("midrst_clear_cycles", 32'(n), 32'd64);
        check("midrst_clear_cycles_small", 32'(ns), 32'd4);

        for (int i = 0; i < 8; i++) wr(9'(i), 16'(8'hC0 + 8'(i)));
        for (int i = 0; i < 8; i++) rd_s(9'(i), 8'(8'hC0 + 8'(i)), "small_rd");
        rd(9'd7, 16'h00C7, "small_shadow_rd7");

        step();
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
